// File: rtl/siren_gen.sv
// siren_gen: square-wave siren with fixed, swept and alternating tones.
// Start/stop/duration control; speaker toggles on divider expiry.
module siren_gen #(
  parameter int          DIV_W       = 16,
  parameter int          SWEEP_W     = 7,
  parameter int          SWEEP_SHIFT = 6,
  parameter int unsigned BASE_DIV    = 32'h4000,
  parameter int          FAST_BIT    = 22,
  parameter int          SLOW_BIT    = 25,
  parameter int          ALT_BIT     = 27,
  parameter int          DUR_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       mode,
  input  logic [DUR_W-1:0] duration,
  input  logic [DIV_W-1:0] fixed_div,
  output logic             busy,
  output logic             done,
  output logic             speaker
);

  localparam int PH_W = ALT_BIT + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       mode_q;
  logic [DUR_W-1:0] dur_q;
  logic [DIV_W-1:0] fdiv_q;
  logic [PH_W-1:0]  phase_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DUR_W-1:0] dur_cnt;

  logic mode_ok;
  logic accept;
  logic expire;
  logic finish;

  logic [SWEEP_W-1:0] fast_raw, slow_raw;
  logic [SWEEP_W-1:0] fast, slow;
  logic [DIV_W-1:0]   div_fast, div_slow;
  logic [DIV_W-1:0]   div_sel;
  logic               phase_unused;

  assign mode_ok = (mode != 3'd0) && (mode <= 3'd5);
  assign expire  = (dur_q != '0) &&
                   (dur_cnt == dur_q - DUR_W'(1));

  // Triangle sweeps: fold the slice on the direction bit
  assign fast_raw = phase_q[FAST_BIT-1 -: SWEEP_W];
  assign slow_raw = phase_q[SLOW_BIT-1 -: SWEEP_W];
  assign fast = phase_q[FAST_BIT] ? fast_raw : ~fast_raw;
  assign slow = phase_q[SLOW_BIT] ? slow_raw : ~slow_raw;

  assign div_fast = DIV_W'(BASE_DIV) +
                    (DIV_W'(fast) << SWEEP_SHIFT);
  assign div_slow = DIV_W'(BASE_DIV) +
                    (DIV_W'(slow) << SWEEP_SHIFT);

  assign phase_unused = ^phase_q;

  always_comb begin
    div_sel = fdiv_q;
    unique case (mode_q)
      3'd1: div_sel = fdiv_q;
      3'd2: div_sel = div_fast;
      3'd3: div_sel = div_slow;
      3'd4: div_sel = phase_q[ALT_BIT] ? div_slow
                                       : div_fast;
      3'd5: div_sel = phase_q[SLOW_BIT] ? fdiv_q
                                        : (fdiv_q >> 1);
      default: div_sel = fdiv_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && mode_ok) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop || expire) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      speaker <= 1'b0;
      mode_q  <= '0;
      dur_q   <= '0;
      fdiv_q  <= '0;
      phase_q <= '0;
      div_cnt <= '0;
      dur_cnt <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= finish;
      if (accept) begin
        mode_q  <= mode;
        dur_q   <= duration;
        fdiv_q  <= fixed_div;
        phase_q <= '0;
        div_cnt <= '0;
        dur_cnt <= '0;
        speaker <= 1'b0;
      end else if (state_q == RUN) begin
        phase_q <= phase_q + PH_W'(1);
        dur_cnt <= dur_cnt + DUR_W'(1);
        if (div_cnt == '0) begin
          div_cnt <= div_sel;
          speaker <= ~speaker;
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
        // Leaving RUN always parks the speaker low
        if (finish) speaker <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_siren_gen.sv
// tb_siren_gen: directed and random stimulus for siren_gen,
// checked every cycle against a toggle-time reference model.
module tb_siren_gen;

  localparam int DIV_W = 8;
  localparam int DUR_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [2:0]       mode = '0;
  logic [DUR_W-1:0] duration = '0;
  logic [DIV_W-1:0] fixed_div = '0;
  logic             busy, done, speaker;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  siren_gen #(
    .DIV_W(8), .SWEEP_W(3), .SWEEP_SHIFT(1),
    .BASE_DIV(8), .FAST_BIT(4), .SLOW_BIT(6),
    .ALT_BIT(7), .DUR_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stop(stop), .mode(mode), .duration(duration),
    .fixed_div(fixed_div), .busy(busy), .done(done),
    .speaker(speaker)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Divider chosen at RUN cycle t (phase == t mod 256)
  function automatic int div_of(input int md, input int fd,
                                input longint t);
    int p, fs, sl, fv, sv;
    p  = int'(t % 256);
    fs = ((p >> 4) & 1) != 0 ? ((p >> 1) & 7)
                             : 7 - ((p >> 1) & 7);
    sl = ((p >> 6) & 1) != 0 ? ((p >> 3) & 7)
                             : 7 - ((p >> 3) & 7);
    fv = (8 + fs * 2) % 256;
    sv = (8 + sl * 2) % 256;
    case (md)
      1: return fd;
      2: return fv;
      3: return sv;
      4: return ((p >> 7) & 1) != 0 ? sv : fv;
      5: return ((p >> 6) & 1) != 0 ? fd : fd / 2;
      default: return 0;
    endcase
  endfunction

  bit     m_run, m_done, m_spk;
  int     m_mode, m_fd;
  longint m_dur, t, next_tog;

  // Model: speaker toggles at the end of RUN cycles next_tog,
  // each toggle scheduling the next one divider+1 cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_spk  <= 1'b0;
    end else if (!m_run) begin
      m_done <= 1'b0;
      m_spk  <= 1'b0;
      if (start && mode >= 3'd1 && mode <= 3'd5) begin
        m_run    <= 1'b1;
        m_mode   <= int'(mode);
        m_fd     <= int'(fixed_div);
        m_dur    <= longint'(duration);
        t        <= 0;
        next_tog <= 0;
      end
    end else if (stop || (m_dur != 0 && t + 1 == m_dur)) begin
      m_run  <= 1'b0;
      m_done <= 1'b1;
      m_spk  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (t == next_tog) begin
        m_spk    <= !m_spk;
        next_tog <= t + div_of(m_mode, m_fd, t) + 1;
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      chk("model", {29'd0, busy, done, speaker},
          {29'd0, m_run, m_done, m_spk});
  end

  initial begin
    logic [12:0] pat;

    chk("pin_m2_t0", div_of(2, 0, 0), 22);
    chk("pin_m2_t16", div_of(2, 0, 16), 8);
    chk("pin_m2_t18", div_of(2, 0, 18), 10);
    chk("pin_m3_t8", div_of(3, 0, 8), 20);
    chk("pin_m4_t128", div_of(4, 0, 128), 22);
    chk("pin_m5_t64", div_of(5, 10, 64), 10);
    chk("pin_m5_t0", div_of(5, 10, 0), 5);

    step(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    for (int k = 0; k < 100; k++) begin
      chk("idle", {busy, done, speaker}, 3'b000);
      step();
    end

    // mode 1, fixed_div 3, run until stop
    start = 1'b1; mode = 3'd1; fixed_div = 8'd3;
    duration = 0;
    step();
    start = 1'b0;
    pat = 13'b1111000011110;
    for (int k = 0; k < 13; k++) begin
      chk("m1_busy", busy, 1'b1);
      chk("m1_spk", speaker, pat[k]);
      step();
    end
    stop = 1'b1;
    step();
    chk("m1_stop", {busy, done, speaker}, 3'b010);
    stop = 1'b0;
    step();
    chk("m1_after", {busy, done, speaker}, 3'b000);

    // mode 1, divider 0, duration 10
    start = 1'b1; mode = 3'd1; fixed_div = 8'd0;
    duration = 10;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("d10_busy", busy, 1'b1);
      chk("d10_spk", speaker, (k % 2) == 1);
      step();
    end
    chk("d10_end", {busy, done, speaker}, 3'b010);
    step();
    chk("d10_after", {busy, done, speaker}, 3'b000);

    // stop coinciding with expiry: one done pulse
    start = 1'b1; mode = 3'd1; fixed_div = 8'd2;
    duration = 5;
    step();
    start = 1'b0;
    step(4);
    chk("both_busy", busy, 1'b1);
    stop = 1'b1;
    step();
    chk("both_end", {busy, done, speaker}, 3'b010);
    stop = 1'b0;
    step();
    chk("both_after", {busy, done, speaker}, 3'b000);
    step(2);

    // mode 2 sweep
    start = 1'b1; mode = 3'd2; duration = 0;
    step();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 23) chk("m2_k23", speaker, 1'b1);
      if (k == 24) chk("m2_k24", speaker, 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(3);

    // mode 4 with ignored restart at cycle 50
    start = 1'b1; mode = 3'd4; duration = 0;
    fixed_div = 8'd7;
    step();
    for (int k = 0; k < 300; k++) begin
      start = (k == 50);
      if (k == 50) begin
        mode = 3'd1;
        fixed_div = 8'd0;
      end
      step();
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    chk("m4_stop", {busy, done}, 2'b01);
    stop = 1'b0;
    step();
    chk("m4_after", {busy, done}, 2'b00);
    step(2);

    // reset mid-run
    start = 1'b1; mode = 3'd2; duration = 100;
    step();
    start = 1'b0;
    step(37);
    chk("rst_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_now", {busy, done, speaker}, 3'b000);
    step(3);
    rst_n = 1'b1;
    step(20);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      mode  = 3'($urandom_range(0, 7));
      fixed_div = ($urandom_range(0, 9) == 0)
                  ? 8'($urandom_range(0, 255))
                  : 8'($urandom_range(0, 20));
      duration = ($urandom_range(0, 3) == 0)
                 ? 0 : $urandom_range(1, 300);
      step();
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/siren_gen.md
SIREN_GEN -- requirements
Module: siren_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DIV_W, 16: half-period divider width.
- SWEEP_W, 7: triangle sweep value width.
- SWEEP_SHIFT, 6: left shift applied to the sweep value.
- BASE_DIV, 16'h4000: divider offset.
- FAST_BIT, 22: fast-sweep direction bit; legal when FAST_BIT >= SWEEP_W.
- SLOW_BIT, 25: slow-sweep direction bit; legal when SLOW_BIT >= SWEEP_W.
- ALT_BIT, 27: alternate-mode select bit.
- DUR_W, 32: duration counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: request pulse.
- stop, in, 1: abort request.
- mode, in, 3: tone mode.
- duration, in, DUR_W: run length in cycles; 0 = run until stop.
- fixed_div, in, DIV_W: divider for modes 1 and 5.
- busy, out, 1: high while running.
- done, out, 1: one-cycle end pulse.
- speaker, out, 1: square-wave output.

Function
REQ-003 Two-state FSM, IDLE and RUN; the FSM is in IDLE after reset.
REQ-004 Start acceptance, IDLE only: start=1 with mode in 1..5 latches mode, duration and fixed_div, clears the phase counter (ALT_BIT+1 bits), clears the divider counter, and enters RUN on the next edge.
REQ-005 start is ignored in IDLE when mode is 0, 6 or 7: no busy, no done.
REQ-006 start is ignored in RUN; latched values and counters are unaffected.
REQ-007 In IDLE, stop is ignored. When start and stop are both high in IDLE, the start is accepted.
REQ-008 busy=1 exactly while the FSM is in RUN.
REQ-009 In RUN, the phase counter increments by 1 every cycle and wraps modulo 2^(ALT_BIT+1).
REQ-010 Sweep terms; every bit slice is SWEEP_W bits wide and ends at the named MSB:
- fast = phase[FAST_BIT] ? phase[FAST_BIT-1 -: SWEEP_W] : the bitwise inverse of that slice.
- slow = the same construction with SLOW_BIT.
REQ-011 Divider selection by latched mode:
- 1: fixed_div.
- 2: BASE_DIV + (fast << SWEEP_SHIFT).
- 3: BASE_DIV + (slow << SWEEP_SHIFT).
- 4: phase[ALT_BIT] ? mode-3 value : mode-2 value.
- 5: phase[SLOW_BIT] ? fixed_div : (fixed_div >> 1).
REQ-012 The divider sum is computed at DIV_W bits and truncated; overflow wraps silently.
REQ-013 Divider counter, RUN only: when it equals 0, speaker toggles and the counter reloads the current divider; otherwise it decrements by 1. The half-period is therefore divider+1 cycles.
REQ-014 Divider 0 is legal: speaker toggles every RUN cycle.
REQ-015 The first RUN cycle sees counter==0, so speaker goes 1 at the end of the first RUN cycle.
REQ-016 duration is nonzero: RUN lasts exactly duration cycles. Then the FSM enters IDLE, and done=1 in the first IDLE cycle.
REQ-017 duration is 0: RUN continues until stop.
REQ-018 stop=1 in RUN: the FSM enters IDLE on the next edge, and done=1 in the first IDLE cycle.
REQ-019 stop on the same edge as duration expiry produces a single done pulse.
REQ-020 In IDLE, speaker is forced to 0, and the divider and phase counters hold their values.
REQ-021 done is high for exactly one cycle per completed run.
REQ-022 All outputs are registered.

Reset
REQ-023 rst_n=0 asynchronously forces IDLE and clears the phase counter, divider counter and duration counter.
REQ-024 Reset values: busy=0, done=0, speaker=0, all latched inputs 0.
REQ-025 Reset asserted mid-run aborts the run with no done pulse.
REQ-026 Leaving reset needs no start; the block waits in IDLE.

Verification
Directed scenarios; test parameters where stated: SWEEP_W=3, SWEEP_SHIFT=1, BASE_DIV=8, FAST_BIT=4, SLOW_BIT=6, ALT_BIT=7, DIV_W=8.
REQ-027 Reset release with no stimulus -> busy=0, done=0, speaker=0 held for 100 cycles.
REQ-028 start with mode=1, fixed_div=3, duration=0 -> busy rises 1 cycle after start. speaker rises at the end of the first RUN cycle, then toggles every 4 cycles until stop.
REQ-029 start with mode=1, fixed_div=0, duration=10 -> busy high for exactly 10 cycles and speaker toggles every cycle. Then done=1 for 1 cycle and speaker=0.
REQ-030 Test parameters, mode=2, duration=0 -> while phase[4]=0, divider = 8+2*(~phase[3:1]), first value 22. While phase[4]=1, divider = 8+2*phase[3:1]. Reload values are checked against a reference model.
REQ-031 mode=4 run, with start pulsed again at cycle 50 and stop at cycle 300 -> the second start has no effect. busy falls one edge after stop, then done is a single pulse.
REQ-032 rst_n low at cycle 37 of a duration=100 run -> busy, speaker and done go 0 immediately, with no done pulse afterwards.
